// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state and byte-lane select mask for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  // Big-endian lanes: byte offset k selects sel bit dw/8-1-k, spanning 2**size lanes downward.
  function automatic logic [7:0] sel_mask(input logic [1:0] size, input logic [2:0] off, input int dw);
    int n;
    n = 1 << size;
    return 8'(((1 << n) - 1) << (dw / 8 - int'(off) - n));
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational store data replication and load byte extraction with sign/zero extension.
import lsu_pkg::*;

module lsu_lane #(
  parameter int DW = 32
) (
  input  logic [1:0]    st_size,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    ld_size,
  input  logic [2:0]    ld_off,
  input  logic          ld_signed,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] sdata,
  output logic [DW-1:0] ldata
);
  logic [3:0]    nbytes;
  logic [6:0]    sh;
  logic [DW-1:0] rsh;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [31:0]   w;

  assign nbytes = 4'd1 << ld_size;
  // Shift the addressed bytes down so their least significant byte lands in lane NB-1.
  assign sh  = 7'(DW) - 7'({ld_off, 3'b000}) - {nbytes, 3'b000};
  assign rsh = rdata >> sh;
  assign b   = rsh[7:0];
  assign h   = rsh[15:0];
  assign w   = rsh[31:0];

  always_comb begin
    sdata = st_size == SZ_B ? {(DW/8){wdata[7:0]}} :
            st_size == SZ_H ? {(DW/16){wdata[15:0]}} :
            st_size == SZ_W ? {(DW/32){wdata[31:0]}} : wdata;
    ldata = ld_size == SZ_B ? (ld_signed ? DW'($signed(b)) : DW'(b)) :
            ld_size == SZ_H ? (ld_signed ? DW'($signed(h)) : DW'(h)) :
            ld_size == SZ_W ? (ld_signed ? DW'($signed(w)) : DW'(w)) : rsh;
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit to a classic Wishbone bus, DW 32/64, big-endian lanes.
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
import lsu_pkg::*;

module lsu #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req,
  input  logic            i_we,
  input  logic [1:0]      i_size,
  input  logic            i_signed,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic            o_busy,
  output logic [DW-1:0]   o_data,
  output logic            o_valid,
  output logic            o_error,
  output logic [AW-1:0]   o_wb_addr,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [DW/8-1:0] o_wb_sel,
  output logic [DW-1:0]   o_wb_dat,
  input  logic [DW-1:0]   i_wb_dat,
  input  logic            i_wb_ack,
  input  logic            i_wb_err
);
  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);

  state_t        state;
  logic [OB-1:0] lane_off;
  logic [7:0]    sel8;
  logic          bad;
  logic [1:0]    r_size;
  logic [2:0]    r_off;
  logic          r_signed;
  logic [DW-1:0] sdata, ldata;
  logic          to_hit;

  assign lane_off = i_addr[OB-1:0];
  assign sel8     = sel_mask(i_size, 3'(lane_off), DW);
  // Misalignment: any address bit below the access size set; dword is illegal on a 32-bit bus.
  assign bad      = (i_size == SZ_D && DW == 32) || |(i_addr[2:0] & ((3'd1 << i_size) - 3'd1));

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign to_hit = cnt == CW'(TIMEOUT - 1);
`else
  logic unused_to;
  assign to_hit    = 1'b0;
  assign unused_to = ^TIMEOUT;
`endif

  lsu_lane #(.DW(DW)) u_lane (
    .st_size  (i_size),
    .wdata    (i_wdata),
    .ld_size  (r_size),
    .ld_off   (r_off),
    .ld_signed(r_signed),
    .rdata    (i_wb_dat),
    .sdata    (sdata),
    .ldata    (ldata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_error   <= 1'b0;
      o_data    <= '0;
      o_wb_addr <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_sel  <= '0;
      o_wb_dat  <= '0;
      r_size    <= SZ_B;
      r_off     <= '0;
      r_signed  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_error <= 1'b0;
      if (state == S_IDLE) begin
        if (i_req && bad) begin
          o_error <= 1'b1;
        end else if (i_req) begin
          state     <= S_BUS;
          o_busy    <= 1'b1;
          o_wb_cyc  <= 1'b1;
          o_wb_stb  <= 1'b1;
          o_wb_we   <= i_we;
          o_wb_addr <= {i_addr[AW-1:OB], {OB{1'b0}}};
          o_wb_sel  <= sel8[NB-1:0];
          o_wb_dat  <= i_we ? sdata : '0;
          r_size    <= i_size;
          r_off     <= 3'(lane_off);
          r_signed  <= i_signed;
`ifdef LSU_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
      end else if (i_wb_ack || i_wb_err || to_hit) begin
        state    <= S_IDLE;
        o_busy   <= 1'b0;
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        o_valid  <= i_wb_ack && !i_wb_err;
        o_error  <= i_wb_err || !i_wb_ack;
        if (i_wb_ack && !i_wb_err && !o_wb_we)
          o_data <= ldata;
      end else begin
`ifdef LSU_TIMEOUT_EN
        cnt <= cnt + 1'b1;
`endif
      end
    end
  end
endmodule
